// File: rtl/nn_seq_pkg.sv
// Shared types and defaults for the classifier inference sequencer.
package nn_seq_pkg;

    localparam int IMG_BITS_DEF       = 256;
    localparam int LABEL_BITS_DEF     = 10;
    localparam int TIMEOUT_CYCLES_DEF = 512;

    localparam logic [3:0] CLASS_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_REPORT,
        S_FLUSH
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  inc,
    output logic [COUNT_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + COUNT_BITS'(1);
    end

endmodule

// File: rtl/inference_sequencer.sv
// Runs the classifier one image at a time: load, wait for done (with timeout),
// report the prediction and keep running accuracy statistics.
module inference_sequencer
    import nn_seq_pkg::*;
#(
    parameter int IMG_BITS       = IMG_BITS_DEF,
    parameter int LABEL_BITS     = LABEL_BITS_DEF,
    parameter int CLASS_BITS     = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int COUNT_BITS     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMG_BITS-1:0]   in_image,
    input  logic [LABEL_BITS-1:0] in_label,
    output logic [IMG_BITS-1:0]   nn_input,
    output logic                  nn_load,
    output logic                  nn_reset,
    input  logic                  nn_done,
    input  logic [CLASS_BITS-1:0] nn_max,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CLASS_BITS-1:0] res_class,
    output logic                  res_correct,
    output logic                  res_timeout,
    input  logic                  stat_clear,
    output logic [COUNT_BITS-1:0] total_count,
    output logic [COUNT_BITS-1:0] correct_count,
    output logic [COUNT_BITS-1:0] timeout_count,
    output logic                  busy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    seq_state_t            state;
    logic [LABEL_BITS-1:0] label_q;
    logic [CW-1:0]         wait_cnt;
    logic                  res_hs;

    // Out-of-range classes never match, so a class >= LABEL_BITS is incorrect.
    function automatic logic class_hits(input logic [CLASS_BITS-1:0] c,
                                        input logic [LABEL_BITS-1:0] lbl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < LABEL_BITS; i++)
            if (c == CLASS_BITS'(i)) hit = lbl[i];
        return hit;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            nn_input    <= '0;
            label_q     <= '0;
            nn_load     <= 1'b0;
            wait_cnt    <= '0;
            res_valid   <= 1'b0;
            res_class   <= '0;
            res_timeout <= 1'b0;
            res_correct <= 1'b0;
        end else begin
            nn_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        nn_input <= in_image;
                        label_q  <= in_label;
                        nn_load  <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    // done is checked first so it wins on the final timeout cycle
                    if (nn_done) begin
                        res_class   <= nn_max;
                        res_timeout <= 1'b0;
                        res_correct <= class_hits(nn_max, label_q);
                        res_valid   <= 1'b1;
                        state       <= S_REPORT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        res_class   <= CLASS_BITS'(CLASS_NONE);
                        res_timeout <= 1'b1;
                        res_correct <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_FLUSH;
                    end
                end
                S_FLUSH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state == S_IDLE) && !reset;
    assign busy     = (state != S_IDLE) && !reset;
    assign nn_reset = reset || (state == S_FLUSH);
    assign res_hs   = (state == S_REPORT) && res_valid && res_ready;

    sat_counter #(.COUNT_BITS(COUNT_BITS)) u_total (
        .clk(clk), .clr(reset || stat_clear), .inc(res_hs), .count(total_count)
    );
    sat_counter #(.COUNT_BITS(COUNT_BITS)) u_correct (
        .clk(clk), .clr(reset || stat_clear), .inc(res_hs && res_correct), .count(correct_count)
    );
    sat_counter #(.COUNT_BITS(COUNT_BITS)) u_timeout (
        .clk(clk), .clr(reset || stat_clear), .inc(res_hs && res_timeout), .count(timeout_count)
    );

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench: driver pushes expected results, stub network follows a plan,
// monitor checks handshakes, timing, payload stability and counters.
module tb_inference_sequencer;

    localparam int IB = 256, LB = 10, CB = 4, TO = 512, CNTB = 16, SB = 3;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, nn_done = 1'b0, stat_clear = 1'b0;
    logic [IB-1:0] in_image = '0;
    logic [LB-1:0] in_label = '0;
    logic [CB-1:0] nn_max = '0;
    logic res_ready, rnd_rr = 1'b0;
    int rr_mode = 1;

    logic in_ready, nn_load, nn_reset, res_valid, res_correct, res_timeout, busy;
    logic [IB-1:0] nn_input;
    logic [CB-1:0] res_class;
    logic [CNTB-1:0] total_count, correct_count, timeout_count;

    logic s_in_ready, s_nn_load, s_nn_reset, s_res_valid, s_res_correct, s_res_timeout, s_busy;
    logic [IB-1:0] s_nn_input;
    logic [CB-1:0] s_res_class;
    logic [SB-1:0] s_total, s_correct, s_timeout;

    assign res_ready = (rr_mode == 1) || ((rr_mode == 2) && rnd_rr);

    inference_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_image(in_image), .in_label(in_label), .nn_input(nn_input),
        .nn_load(nn_load), .nn_reset(nn_reset), .nn_done(nn_done), .nn_max(nn_max),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_correct(res_correct), .res_timeout(res_timeout), .stat_clear(stat_clear),
        .total_count(total_count), .correct_count(correct_count),
        .timeout_count(timeout_count), .busy(busy)
    );

    // Narrow-counter copy on the same stimulus exercises saturation quickly.
    inference_sequencer #(.COUNT_BITS(SB)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_image(in_image), .in_label(in_label), .nn_input(s_nn_input),
        .nn_load(s_nn_load), .nn_reset(s_nn_reset), .nn_done(nn_done), .nn_max(nn_max),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_class(s_res_class),
        .res_correct(s_res_correct), .res_timeout(s_res_timeout), .stat_clear(stat_clear),
        .total_count(s_total), .correct_count(s_correct),
        .timeout_count(s_timeout), .busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IB-1:0] img;
        logic [CB-1:0] cls;
        logic          corr;
        logic          tmo;
    } exp_t;
    typedef struct {
        int            d;   // WAIT cycle index at which done is raised; -1 = never
        logic [CB-1:0] m;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int vectors = 0, fails = 0, cyc = 0, exp_rise = -1;
    bit stray_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rnd_rr = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [IB-1:0] act, input logic [IB-1:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic int satv(input int v, input int bits);
        return (v > (1 << bits) - 1) ? (1 << bits) - 1 : v;
    endfunction

    // Stub network: raises done on the planned WAIT cycle, strays only in IDLE/FLUSH.
    bit st_active = 1'b0;
    int st_k = 0;
    plan_t st_p;
    always @(negedge clk) begin
        nn_done = 1'b0;
        if (reset) begin
            st_active = 1'b0;
        end else if (nn_load) begin
            if (plan_q.size() == 0) begin
                chk("stub_plan_available", 0, 1);
            end else begin
                st_p      = plan_q.pop_front();
                st_active = 1'b1;
                st_k      = 0;
                exp_rise  = (st_p.d >= 0 && st_p.d < TO) ? cyc + 2 + st_p.d : cyc + 1 + TO;
            end
        end else if (st_active) begin
            if (st_k == st_p.d) begin
                nn_done = 1'b1;
                nn_max  = st_p.m;
            end
            st_k++;
            if ((st_p.d >= 0 && st_k > st_p.d) || res_valid) st_active = 1'b0;
        end else if (stray_en && (!busy || nn_reset)) begin
            nn_done = 1'($urandom_range(0, 1));
            nn_max  = CB'($urandom);
        end
    end

    // Monitor / scoreboard
    bit prev_rv = 1'b0, have_cur = 1'b0, exp_load = 1'b0, flush_pend = 1'b0, idle_m = 1'b0;
    exp_t cur;
    int m_tot = 0, m_cor = 0, m_tmo = 0;
    always @(negedge clk) begin
        bit hs, acc;
        if (reset) begin
            chk("nn_reset_during_reset", nn_reset, 1);
            chk("in_ready_during_reset", in_ready, 0);
            exp_q.delete();
            have_cur = 0; flush_pend = 0; exp_load = 0; idle_m = 1; prev_rv = 0;
            m_tot = 0; m_cor = 0; m_tmo = 0;
        end else begin
            chk("nn_load", nn_load, exp_load);
            chk("nn_reset", nn_reset, flush_pend);
            chk("in_ready", in_ready, idle_m);
            chk("busy", busy, !idle_m);
            chk("total_count", total_count, satv(m_tot, CNTB));
            chk("correct_count", correct_count, satv(m_cor, CNTB));
            chk("timeout_count", timeout_count, satv(m_tmo, CNTB));
            chk("small_total", s_total, satv(m_tot, SB));
            chk("small_correct", s_correct, satv(m_cor, SB));
            chk("small_timeout", s_timeout, satv(m_tmo, SB));
            if (res_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", res_valid, 0);
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    chk("res_class", res_class, cur.cls);
                    chk("res_correct", res_correct, cur.corr);
                    chk("res_timeout", res_timeout, cur.tmo);
                    chk("nn_input", nn_input, cur.img);
                    chk("res_latency", cyc, exp_rise);
                end
            end else if (res_valid && have_cur) begin
                chk("res_class_stable", res_class, cur.cls);
                chk("res_correct_stable", res_correct, cur.corr);
                chk("res_timeout_stable", res_timeout, cur.tmo);
            end
            acc = in_valid && in_ready;
            hs  = res_valid && res_ready;
            exp_load = acc;
            if (acc) idle_m = 0;
            if (flush_pend) idle_m = 1;
            flush_pend = hs;
            if (stat_clear) begin
                m_tot = 0; m_cor = 0; m_tmo = 0;
            end else if (hs && have_cur) begin
                m_tot++;
                if (cur.corr) m_cor++;
                if (cur.tmo) m_tmo++;
            end
            prev_rv = res_valid;
        end
    end

    task automatic send(input logic [LB-1:0] lbl, input int d, input logic [CB-1:0] m,
                        input bit hold);
        exp_t e;
        plan_t p;
        bit timed;
        int g = 0;
        for (int i = 0; i < IB / 32; i++) e.img[i*32 +: 32] = $urandom;
        timed  = (d >= 0) && (d < TO);
        e.cls  = timed ? m : 4'hF;
        e.tmo  = !timed;
        e.corr = (timed && (m < LB)) ? lbl[m] : 1'b0;
        p.d = d;
        p.m = m;
        in_image = e.img;
        in_label = lbl;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            g++;
            if (g > 3000) begin
                chk("accept_wait_expired", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(e);
        plan_q.push_back(p);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy || res_valid) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("drain_wait_expired", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv();
        int g = 0;
        while (res_valid !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("result_wait_expired", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        fails++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] lbl;
        int dig;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_nn_input", nn_input, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_class", res_class, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_res_correct", res_correct, 0);
        chk("rst_nn_load", nn_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", total_count, 0);
        @(posedge clk);
        #1;

        // single image, digit 3, correct
        send(10'b0000001000, 7, 4'd3, 0);
        drain();
        chk("single_total", total_count, 1);
        chk("single_correct", correct_count, 1);

        // misclassification with 20 cycles of backpressure
        rr_mode = 0;
        send(10'b0010000000, 5, 4'd2, 0);
        wait_rv();
        repeat (20) @(posedge clk);
        #1 rr_mode = 1;
        drain();

        // timeout, then done on the last WAIT cycle
        send(10'b0000010000, -1, 4'd0, 0);
        drain();
        chk("timeout_count_one", timeout_count, 1);
        send(10'b0000010000, TO - 1, 4'd4, 0);
        drain();

        // ten back-to-back images with stray done pulses
        stray_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lbl = LB'(1) << i;
            send(lbl, $urandom_range(0, 10), (i == 5) ? 4'd6 : CB'(i), 1);
        end
        in_valid = 1'b0;
        drain();

        // random images, random result backpressure
        rr_mode = 2;
        for (int i = 0; i < 20; i++) begin
            dig = $urandom_range(0, 9);
            lbl = ($urandom_range(0, 3) == 0) ? LB'($urandom) : (LB'(1) << dig);
            send(lbl, $urandom_range(0, 30),
                 ($urandom_range(0, 2) == 0) ? CB'($urandom) : CB'(dig), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rr_mode = 1;
        drain();

        // reset in the middle of WAIT: no result, counters cleared
        send(10'b0000000001, -1, 4'd0, 0);
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        chk("post_reset_total", total_count, 0);

        // stat_clear coincident with a result handshake
        send(10'b0100000000, 3, 4'd8, 0);
        drain();
        rr_mode = 0;
        send(10'b0000000100, 4, 4'd2, 0);
        wait_rv();
        @(posedge clk);
        #1 rr_mode = 1; stat_clear = 1'b1;
        @(posedge clk);
        #1 stat_clear = 1'b0;
        @(negedge clk);
        chk("clear_total", total_count, 0);
        chk("clear_correct", correct_count, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
